// File: rtl/cpu_seq_pkg.sv
// Shared types and encodings for the two-byte-instruction CPU sequencer.
// Opcodes live in ir1[7:4]; any opcode with bit 7 set is an ALU operation.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_FETCH1 = 3'd0,
    ST_FETCH2 = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDI  = 4'b0001;
  localparam logic [3:0] OP_LDM  = 4'b0010;
  localparam logic [3:0] OP_STM  = 4'b0011;
  localparam logic [3:0] OP_JMP  = 4'b0100;
  localparam logic [3:0] OP_RSV5 = 4'b0101;
  localparam logic [3:0] OP_RSV6 = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b0111;

  localparam logic [1:0] M2R_IMM = 2'b00;
  localparam logic [1:0] M2R_RAM = 2'b01;
  localparam logic [1:0] M2R_ALU = 2'b10;

  localparam logic [2:0] JC_ALWAYS = 3'b000;
  localparam logic [2:0] JC_C      = 3'b001;
  localparam logic [2:0] JC_NC     = 3'b101;
  localparam logic [2:0] JC_Z      = 3'b010;
  localparam logic [2:0] JC_NZ     = 3'b110;

  function automatic logic is_alu(input logic [7:0] ir1);
    return ir1[7];
  endfunction

endpackage

// File: rtl/cpu_seq_jump_eval.sv
// Combinational jump-condition evaluation against the held C/Z flags.
// Unlisted condition codes never jump.
module cpu_seq_jump_eval
  import cpu_seq_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      JC_ALWAYS: taken = 1'b1;
      JC_C:      taken = c_flag;
      JC_NC:     taken = ~c_flag;
      JC_Z:      taken = z_flag;
      JC_NZ:     taken = ~z_flag;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: 3 cycles per instruction, 4 for LDM; HALT is absorbing.
// run=0 freezes all state and idles every strobe for that cycle.
module cpu_sequencer
  import cpu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       run,
  input  logic [7:0] rom_data,
  output logic [7:0] pc,
  output logic       ram_n_cs,
  output logic       ram_n_oe,
  output logic       ram_n_we,
  output logic [7:0] ram_addr,
  output logic       reg_write,
  output logic [2:0] reg_rd_addr1,
  output logic [2:0] reg_rd_addr2,
  output logic [2:0] reg_wr_addr,
  output logic [1:0] mem_to_reg,
  output logic [7:0] imm,
  output logic       alu_op,
  output logic [2:0] alu_func,
  input  logic       carry_f,
  input  logic       zero_f,
  output logic       halt
);

  state_t     state;
  logic [7:0] ir1;
  logic [7:0] ir2;
  logic       c_flag;
  logic       z_flag;
  logic [3:0] opcode;
  logic       alu_instr;
  logic       jmp_taken;
  logic       ir1_unused;

  assign opcode    = ir1[7:4];
  assign alu_instr = is_alu(ir1);
  // ir1[3] carries no meaning in any encoding.
  assign ir1_unused = ir1[3];

  cpu_seq_jump_eval u_jump_eval (
    .cond   (ir1[2:0]),
    .c_flag (c_flag),
    .z_flag (z_flag),
    .taken  (jmp_taken)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state  <= ST_FETCH1;
      pc     <= 8'h00;
      ir1    <= 8'h00;
      ir2    <= 8'h00;
      c_flag <= 1'b0;
      z_flag <= 1'b0;
    end else if (run) begin
      case (state)
        ST_FETCH1: begin
          ir1   <= rom_data;
          pc    <= pc + 8'd1;
          state <= ST_FETCH2;
        end
        ST_FETCH2: begin
          ir2   <= rom_data;
          pc    <= pc + 8'd1;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (alu_instr) begin
            c_flag <= carry_f;
            z_flag <= zero_f;
            state  <= ST_FETCH1;
          end else begin
            case (opcode)
              OP_LDM:  state <= ST_WB;
              OP_HALT: state <= ST_HALT;
              OP_JMP: begin
                if (jmp_taken) pc <= ir2;
                state <= ST_FETCH1;
              end
              default: state <= ST_FETCH1;
            endcase
          end
        end
        ST_WB:   state <= ST_FETCH1;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH1;
      endcase
    end
  end

  // Strobes decode the async-reset state, so reset idles them immediately.
  always_comb begin
    ram_n_cs   = 1'b1;
    ram_n_oe   = 1'b1;
    ram_n_we   = 1'b1;
    reg_write  = 1'b0;
    alu_op     = 1'b0;
    mem_to_reg = M2R_IMM;
    if (run) begin
      case (state)
        ST_EXEC: begin
          if (alu_instr) begin
            alu_op     = 1'b1;
            reg_write  = 1'b1;
            mem_to_reg = M2R_ALU;
          end else begin
            case (opcode)
              OP_LDI: reg_write = 1'b1;
              OP_LDM: begin
                ram_n_cs = 1'b0;
                ram_n_oe = 1'b0;
              end
              OP_STM: begin
                ram_n_cs = 1'b0;
                ram_n_we = 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_WB: begin
          if (!alu_instr && opcode == OP_LDM) begin
            ram_n_cs   = 1'b0;
            ram_n_oe   = 1'b0;
            reg_write  = 1'b1;
            mem_to_reg = M2R_RAM;
          end
        end
        default: ;
      endcase
    end
  end

  assign reg_rd_addr1 = ir1[2:0];
  assign reg_rd_addr2 = ir2[6:4];
  assign reg_wr_addr  = alu_instr ? ir2[2:0] : ir1[2:0];
  assign alu_func     = ir1[6:4];
  assign ram_addr     = ir2;
  assign imm          = ir2;
  assign halt         = (state == ST_HALT);

endmodule
